// File: rtl/vga_pkg.sv
// Shared widths, default 640x480@60 timing and pipeline bounds
// for the VGA display timing controller.
package vga_pkg;

  localparam int HCNT_W_DEF = 12;
  localparam int VCNT_W_DEF = 11;
  localparam int CDW_DEF    = 4;

  localparam int H_TOTAL_DEF      = 800;
  localparam int H_SYNC_END_DEF   = 96;
  localparam int H_DATA_BEGIN_DEF = 144;
  localparam int H_DATA_END_DEF   = 784;
  localparam int V_TOTAL_DEF      = 525;
  localparam int V_SYNC_END_DEF   = 2;
  localparam int V_DATA_BEGIN_DEF = 35;
  localparam int V_DATA_END_DEF   = 515;

  localparam int BAR_SHIFT = 4;

  localparam int OUT_STAGES_MIN = 1;
  localparam int OUT_STAGES_MAX = 4;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic sof;
    logic eol;
  } vga_ctl_t;

  function automatic int clamp_stages(input int n);
    if (n < OUT_STAGES_MIN) return OUT_STAGES_MIN;
    if (n > OUT_STAGES_MAX) return OUT_STAGES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: wrapping counter plus raw sync
// and in-window flags derived from the shadow fields.
module vga_axis_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         adv,
  input  logic [W-1:0] total,
  input  logic [W-1:0] sync_end,
  input  logic [W-1:0] wbeg,
  input  logic [W-1:0] wend,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         sync,
  output logic         win
);

  logic [W-1:0] tot;

  assign tot  = (total < W'(2)) ? W'(2) : total;
  assign wrap = adv && (cnt >= tot - W'(1));
  assign sync = cnt < sync_end;
  assign win  = (cnt >= wbeg) && (cnt < wend);

  // count up on advance, wrap at the clamped total
  always_ff @(posedge clk) begin
    if (!resetn || clr) cnt <= '0;
    else if (wrap)      cnt <= '0;
    else if (adv)       cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/vga_disp_ctrl.sv
// VGA timing controller with frame-synchronous shadow timing set.
// Optional colour-bar generator under VGA_TESTPAT_EN.
module vga_disp_ctrl
  import vga_pkg::*;
#(
  parameter int HCNT_W     = HCNT_W_DEF,
  parameter int VCNT_W     = VCNT_W_DEF,
  parameter int CDW        = CDW_DEF,
  parameter int OUT_STAGES = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en_i,
  input  logic              hsync_pol_i,
  input  logic              vsync_pol_i,
  input  logic [HCNT_W-1:0] htotal_i,
  input  logic [HCNT_W-1:0] hsync_end_i,
  input  logic [HCNT_W-1:0] hdata_begin_i,
  input  logic [HCNT_W-1:0] hdata_end_i,
  input  logic [VCNT_W-1:0] vtotal_i,
  input  logic [VCNT_W-1:0] vsync_end_i,
  input  logic [VCNT_W-1:0] vdata_begin_i,
  input  logic [VCNT_W-1:0] vdata_end_i,
  input  logic              cfg_upd_i,
`ifdef VGA_TESTPAT_EN
  input  logic              tp_en_i,
`endif
  input  logic [3*CDW-1:0]  data_i,
  output logic              data_req_o,
  output logic [CDW-1:0]    red_o,
  output logic [CDW-1:0]    green_o,
  output logic [CDW-1:0]    blue_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              blank_o,
  output logic              sof_o,
  output logic              eol_o,
  output logic              cfg_pend_o
);

  localparam int NS = clamp_stages(OUT_STAGES);
  localparam int DW = 3 * CDW;

  logic [HCNT_W-1:0] sh_ht, sh_hse, sh_hdb, sh_hde;
  logic [VCNT_W-1:0] sh_vt, sh_vse, sh_vdb, sh_vde;
  logic              pend;
  logic              load;

  logic [HCNT_W-1:0] h_cnt;
  logic [VCNT_W-1:0] v_cnt;
  logic              h_wrap, v_wrap;
  logic              h_sync, v_sync;
  logic              h_win, v_win;
  logic              clr;
  logic              active;

  vga_ctl_t          idle_ctl;
  vga_ctl_t          s0_ctl;
  logic [DW-1:0]     s0_rgb;
  vga_ctl_t          ctl_q [NS];
  logic [DW-1:0]     rgb_q [NS];

  assign clr  = !en_i;
  assign load = !resetn || !en_i || (v_wrap && (pend || cfg_upd_i));

  // shadow timing set: follows inputs while idle, else only at frame end
  always_ff @(posedge clk) begin
    if (load) begin
      sh_ht  <= htotal_i;
      sh_hse <= hsync_end_i;
      sh_hdb <= hdata_begin_i;
      sh_hde <= hdata_end_i;
      sh_vt  <= vtotal_i;
      sh_vse <= vsync_end_i;
      sh_vdb <= vdata_begin_i;
      sh_vde <= vdata_end_i;
    end
  end

  // pending flag: set by a request, cleared when the shadow set loads
  always_ff @(posedge clk) begin
    if (!resetn || !en_i || v_wrap) pend <= 1'b0;
    else if (cfg_upd_i)             pend <= 1'b1;
  end

  assign cfg_pend_o = pend;

  vga_axis_cnt #(.W(HCNT_W)) u_hcnt (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (clr),
    .adv      (1'b1),
    .total    (sh_ht),
    .sync_end (sh_hse),
    .wbeg     (sh_hdb),
    .wend     (sh_hde),
    .cnt      (h_cnt),
    .wrap     (h_wrap),
    .sync     (h_sync),
    .win      (h_win)
  );

  vga_axis_cnt #(.W(VCNT_W)) u_vcnt (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (clr),
    .adv      (h_wrap),
    .total    (sh_vt),
    .sync_end (sh_vse),
    .wbeg     (sh_vdb),
    .wend     (sh_vde),
    .cnt      (v_cnt),
    .wrap     (v_wrap),
    .sync     (v_sync),
    .win      (v_win)
  );

  assign active = h_win && v_win;

`ifdef VGA_TESTPAT_EN
  logic [HCNT_W-1:0] hoff;
  logic [2:0]        bar;
  logic [DW-1:0]     bar_rgb;

  assign hoff       = h_cnt - sh_hdb;
  assign bar        = hoff[BAR_SHIFT+2:BAR_SHIFT];
  assign bar_rgb    = {{CDW{bar[2]}}, {CDW{bar[1]}}, {CDW{bar[0]}}};
  assign data_req_o = active && en_i && !tp_en_i;
`else
  assign data_req_o = active && en_i;
`endif

  // idle output levels: syncs inactive, everything else low
  always_comb begin
    idle_ctl       = '0;
    idle_ctl.hs    = ~hsync_pol_i;
    idle_ctl.vs    = ~vsync_pol_i;
  end

  // stage-0 values at the data-request point
  always_comb begin
    s0_ctl = idle_ctl;
    s0_rgb = '0;
    if (en_i) begin
      s0_ctl.hs    = h_sync ^ ~hsync_pol_i;
      s0_ctl.vs    = v_sync ^ ~vsync_pol_i;
      s0_ctl.blank = active;
      s0_ctl.sof   = (h_cnt == '0) && (v_cnt == '0);
      s0_ctl.eol   = active && (h_cnt == sh_hde - HCNT_W'(1));
      if (data_req_o) s0_rgb = data_i;
`ifdef VGA_TESTPAT_EN
      else if (tp_en_i && active) s0_rgb = bar_rgb;
`endif
    end
  end

  // output pipeline keeping sync, colour and pulses aligned
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NS; i++) begin
        ctl_q[i] <= idle_ctl;
        rgb_q[i] <= '0;
      end
    end else begin
      ctl_q[0] <= s0_ctl;
      rgb_q[0] <= s0_rgb;
      for (int i = 1; i < NS; i++) begin
        ctl_q[i] <= ctl_q[i-1];
        rgb_q[i] <= rgb_q[i-1];
      end
    end
  end

  assign hsync_o = ctl_q[NS-1].hs;
  assign vsync_o = ctl_q[NS-1].vs;
  assign blank_o = ctl_q[NS-1].blank;
  assign sof_o   = ctl_q[NS-1].sof;
  assign eol_o   = ctl_q[NS-1].eol;
  assign red_o   = rgb_q[NS-1][CDW-1:0];
  assign green_o = rgb_q[NS-1][2*CDW-1:CDW];
  assign blue_o  = rgb_q[NS-1][3*CDW-1:2*CDW];

endmodule

// File: tb/tb_vga_disp_ctrl.sv
// Bench for vga_disp_ctrl: two instances (1 and 3 output stages)
// checked each cycle against a position-based reference model.
module tb_vga_disp_ctrl;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic       sof;
    logic       eol;
    logic [11:0] rgb;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, en, hpol, vpol, upd, tp;
  logic [11:0] ht, hse, hdb, hde;
  logic [10:0] vt, vse, vdb, vde;
  logic [11:0] data;

  logic       req1, hs1, vs1, bl1, sof1, eol1, pend1;
  logic [3:0] r1, g1, b1;
  logic       req3, hs3, vs3, bl3, sof3, eol3, pend3;
  logic [3:0] r3, g3, b3;

  vga_disp_ctrl #(.OUT_STAGES(1)) dut1 (
    .clk(clk), .resetn(resetn), .en_i(en),
    .hsync_pol_i(hpol), .vsync_pol_i(vpol),
    .htotal_i(ht), .hsync_end_i(hse),
    .hdata_begin_i(hdb), .hdata_end_i(hde),
    .vtotal_i(vt), .vsync_end_i(vse),
    .vdata_begin_i(vdb), .vdata_end_i(vde),
    .cfg_upd_i(upd),
`ifdef VGA_TESTPAT_EN
    .tp_en_i(tp),
`endif
    .data_i(data), .data_req_o(req1),
    .red_o(r1), .green_o(g1), .blue_o(b1),
    .hsync_o(hs1), .vsync_o(vs1), .blank_o(bl1),
    .sof_o(sof1), .eol_o(eol1), .cfg_pend_o(pend1)
  );

  vga_disp_ctrl #(.OUT_STAGES(3)) dut3 (
    .clk(clk), .resetn(resetn), .en_i(en),
    .hsync_pol_i(hpol), .vsync_pol_i(vpol),
    .htotal_i(ht), .hsync_end_i(hse),
    .hdata_begin_i(hdb), .hdata_end_i(hde),
    .vtotal_i(vt), .vsync_end_i(vse),
    .vdata_begin_i(vdb), .vdata_end_i(vde),
    .cfg_upd_i(upd),
`ifdef VGA_TESTPAT_EN
    .tp_en_i(tp),
`endif
    .data_i(data), .data_req_o(req3),
    .red_o(r3), .green_o(g3), .blue_o(b3),
    .hsync_o(hs3), .vsync_o(vs3), .blank_o(bl3),
    .sof_o(sof3), .eol_o(eol3), .cfg_pend_o(pend3)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   armed   = 0;
  int   cnt_req, cnt_hlo;

  int   m_h, m_v, m_pend;
  int   s_ht, s_hse, s_hdb, s_hde, s_vt, s_vse, s_vdb, s_vde;
  rec_t q1[$];
  rec_t q3[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t idle_rec();
    rec_t r;
    r    = '0;
    r.hs = ~hpol;
    r.vs = ~vpol;
    return r;
  endfunction

  function automatic bit m_active();
    return m_h >= s_hdb && m_h < s_hde && m_v >= s_vdb && m_v < s_vde;
  endfunction

  function automatic rec_t s0_rec();
    rec_t r;
    bit   act;
    int   b;
    if (!en) return idle_rec();
    act     = m_active();
    r       = '0;
    r.hs    = (m_h < s_hse) ? hpol : ~hpol;
    r.vs    = (m_v < s_vse) ? vpol : ~vpol;
    r.blank = act;
    r.sof   = (m_h == 0) && (m_v == 0);
    r.eol   = act && (m_h == s_hde - 1);
    if (act && !tp) r.rgb = data;
    else if (act) begin
      b     = ((m_h - s_hdb) / 16) % 8;
      r.rgb = {(b & 4) != 0 ? 4'hF : 4'h0,
               (b & 2) != 0 ? 4'hF : 4'h0,
               (b & 1) != 0 ? 4'hF : 4'h0};
    end
    return r;
  endfunction

  function automatic void load_shadow();
    s_ht = int'(ht);  s_hse = int'(hse);
    s_hdb = int'(hdb); s_hde = int'(hde);
    s_vt = int'(vt);  s_vse = int'(vse);
    s_vdb = int'(vdb); s_vde = int'(vde);
  endfunction

  function automatic void model_edge();
    rec_t s;
    int   htc, vtc, nh;
    bit   last;
    s = s0_rec();
    if (!resetn) begin
      m_h = 0; m_v = 0; m_pend = 0;
      load_shadow();
      q1 = {idle_rec()};
      q3 = {idle_rec(), idle_rec(), idle_rec()};
    end else begin
      q1.push_back(s); void'(q1.pop_front());
      q3.push_back(s); void'(q3.pop_front());
      if (!en) begin
        m_h = 0; m_v = 0; m_pend = 0;
        load_shadow();
      end else begin
        htc  = (s_ht < 2) ? 2 : s_ht;
        vtc  = (s_vt < 2) ? 2 : s_vt;
        last = (m_h == htc - 1) && (m_v == vtc - 1);
        nh   = (m_h + 1) % htc;
        if (nh == 0) m_v = (m_v + 1) % vtc;
        m_h = nh;
        if (last && (m_pend != 0 || upd)) begin
          load_shadow();
          m_pend = 0;
        end else if (upd) m_pend = 1;
      end
    end
  endfunction

  task automatic check();
    rec_t s;
    bit   exp_req;
    s       = s0_rec();
    exp_req = en && m_active() && !tp;
    chk("data_req1", 32'(req1), 32'(exp_req));
    chk("data_req3", 32'(req3), 32'(exp_req));
    chk("out1", 32'({hs1, vs1, bl1, sof1, eol1, b1, g1, r1}), 32'(q1[0]));
    chk("out3", 32'({hs3, vs3, bl3, sof3, eol3, b3, g3, r3}), 32'(q3[0]));
    chk("pend1", 32'(pend1), 32'(m_pend));
    chk("pend3", 32'(pend3), 32'(m_pend));
    cnt_req += int'(req1);
    cnt_hlo += int'(!hs1);
  endtask

  task automatic cycle(input logic r, input logic e, input logic u);
    resetn = r;
    en     = e;
    upd    = u;
    data   = 12'($urandom);
    @(negedge clk);
    if (armed) check();
    @(posedge clk);
    model_edge();
    if (!r) armed = 1;
    #1;
  endtask

  task automatic small_mode();
    ht = 12'd10; hse = 12'd2; hdb = 12'd3; hde = 12'd8;
    vt = 11'd6;  vse = 11'd1; vdb = 11'd2; vde = 11'd5;
  endtask

  task automatic rand_mode();
    ht  = 12'($urandom_range(0, 14));
    hse = 12'($urandom_range(0, 15));
    hdb = 12'($urandom_range(0, 15));
    hde = 12'($urandom_range(0, 15));
    vt  = 11'($urandom_range(0, 7));
    vse = 11'($urandom_range(0, 8));
    vdb = 11'($urandom_range(0, 8));
    vde = 11'($urandom_range(0, 8));
  endtask

  initial begin
    tp = 1'b0;
    hpol = 1'b0;
    vpol = 1'b0;
    small_mode();

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
    hpol = 1'b1; vpol = 1'b1;
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0);
    hpol = 1'b0; vpol = 1'b0;
    cycle(1'b0, 1'b1, 1'b0);

    cnt_req = 0;
    cnt_hlo = 0;
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1, 1'b0);
    chk("frame_req_cnt", 32'(cnt_req), 32'd15);
    chk("frame_hsync_low", 32'(cnt_hlo), 32'd12);
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 1'b0);
    ht = 12'd12;
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 150; i++) cycle(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    small_mode();
    for (int i = 0; i < 80; i++) cycle(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int p;
      p = $urandom_range(0, 99);
      if (p < 3) begin
        rand_mode();
        cycle(1'b1, 1'b1, 1'b1);
      end else if (p < 5) cycle(1'b1, 1'b0, 1'b0);
      else if (p == 5) cycle(1'b0, 1'b1, 1'b0);
      else if (p < 8) begin
        hpol = 1'($urandom);
        vpol = 1'($urandom);
        cycle(1'b1, 1'b1, 1'b0);
      end else if (p < 10) cycle(1'b1, 1'b1, 1'b1);
      else cycle(1'b1, 1'b1, 1'b0);
    end

    ht = 12'd80; hse = 12'd8; hdb = 12'd0; hde = 12'd64;
    vt = 11'd3;  vse = 11'd1; vdb = 11'd0; vde = 11'd2;
    cycle(1'b1, 1'b0, 1'b0);
`ifdef VGA_TESTPAT_EN
    tp = 1'b1;
`endif
    for (int i = 0; i < 240; i++) cycle(1'b1, 1'b1, 1'b0);
    tp = 1'b0;
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
